// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 4-word register window, byte FIFO and a
// bit-timing FSM. Read data is zero when not selected so it can be ORed onto the bus.
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic [15:0] i_address,
  input  logic [15:0] i_data,
  output logic [15:0] o_data,
  output logic        o_tx,
  output logic        o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_n;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count;
  logic           ovf;
  logic [15:0]    div;
  logic [15:0]    cnt, cnt_n;
  logic [2:0]     bitcnt, bitcnt_n;
  logic [7:0]     shreg, shreg_n;
  logic           tx, tx_n;
  logic           irq;

  logic       sel, wr_sel, full, empty, push, push_ok, pop;
  logic [1:0] off;

  assign sel     = (i_address[15:2] == BASE_ADDR[15:2]);
  assign off     = i_address[1:0];
  assign wr_sel  = i_wr && sel;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_sel && (off == 2'd0);
  // A push into a full FIFO is dropped even if the transmitter pops this cycle.
  assign push_ok = push && !full;

  always_ff @(posedge i_clk)
    if (push_ok) mem[wptr] <= i_data[7:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      div   <= CLK_DIV;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && full)                                 ovf <= 1'b1;
      else if (wr_sel && (off == 2'd1) && i_data[3])    ovf <= 1'b0;
      if (wr_sel && (off == 2'd2)) div <= (i_data == 16'd0) ? 16'd1 : i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      tx     <= 1'b1;
      irq    <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      tx     <= tx_n;
      irq    <= (state == IDLE) && empty;
    end
  end

  // Every bit boundary reloads from the live divisor, so DIV writes land there.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    tx_n     = tx;
    pop      = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shreg_n = mem[rptr];
        cnt_n   = div - 16'd1;
        tx_n    = 1'b0;
        state_n = START;
      end
      START: if (cnt == 16'd0) begin
        tx_n     = shreg[0];
        cnt_n    = div - 16'd1;
        bitcnt_n = 3'd0;
        state_n  = DATA;
      end else cnt_n = cnt - 16'd1;
      DATA: if (cnt == 16'd0) begin
        cnt_n = div - 16'd1;
        if (bitcnt == 3'd7) begin
          tx_n    = 1'b1;
          state_n = STOP;
        end else begin
          shreg_n  = {1'b0, shreg[7:1]};
          tx_n     = shreg[1];
          bitcnt_n = bitcnt + 3'd1;
        end
      end else cnt_n = cnt - 16'd1;
      STOP: if (cnt == 16'd0) begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = mem[rptr];
          cnt_n   = div - 16'd1;
          tx_n    = 1'b0;
          state_n = START;
        end else state_n = IDLE;
      end else cnt_n = cnt - 16'd1;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    o_data = 16'h0000;
    if (i_rd && sel)
      case (off)
        2'd1:    o_data = {7'd0, 5'(count), ovf, (state != IDLE), empty, full};
        2'd2:    o_data = div;
        default: o_data = 16'h0000;
      endcase
  end

  assign o_tx  = tx;
  assign o_irq = irq;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: byte-queue reference model with frame-level timing,
// plus a serial-line monitor that decodes 8N1 frames and checks them against it.
module tb_uart_tx_mmio;
  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0, rst_n = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata;
  logic        tx, irq;
  int          total = 0, bad = 0;

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(16'd434), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_rd(rd), .i_address(addr),
    .i_data(wdata), .o_data(rdata), .o_tx(tx), .o_irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue; transmitter as "one frame of 10*DIV edges per pop".
  int          cyc = 0, busy_until = 0, next_ok = 0, nframes = 0;
  logic        ovf_m, irq_m;
  logic [15:0] div_m;
  logic [7:0]  mq[$], exp_b[$];
  int          exp_e[$];
  bit          mon_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_rst();
    mq.delete(); exp_b.delete(); exp_e.delete();
    ovf_m = 1'b0; div_m = 16'd434; busy_until = 0; next_ok = 0; irq_m = 1'b1;
  endtask

  task automatic model_edge();
    bit fullb;
    logic [7:0] b;
    fullb = (mq.size() == DEPTH);
    irq_m = !((cyc - 1) < busy_until) && (mq.size() == 0);
    if (mq.size() > 0 && cyc >= next_ok) begin
      b = mq.pop_front();
      exp_b.push_back(b);
      exp_e.push_back(cyc);
      busy_until = cyc + 10 * int'(div_m);
      next_ok    = busy_until;
    end
    if (wr && addr[15:2] == BASE[15:2])
      case (addr[1:0])
        2'd0: if (fullb) ovf_m = 1'b1; else mq.push_back(wdata[7:0]);
        2'd1: if (wdata[3]) ovf_m = 1'b0;
        2'd2: div_m = (wdata == 16'd0) ? 16'd1 : wdata;
        default: ;
      endcase
  endtask

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    logic f, e, bz;
    logic [4:0] c;
    if (a[15:2] != BASE[15:2]) return 16'h0000;
    f = (mq.size() == DEPTH); e = (mq.size() == 0); bz = (cyc < busy_until);
    c = 5'(mq.size());
    case (a[1:0])
      2'd1:    return {7'd0, c, ovf_m, bz, e, f};
      2'd2:    return div_m;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge();
    #1;
    chk("irq", irq, irq_m);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    wr = 1'b1; addr = a; wdata = d;
    cycle();
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] v);
    rd = 1'b1; addr = a;
    #1 v = rdata;
    rd = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a);
    logic [15:0] v;
    bus_rd(a, v);
    chk(tag, v, exp_rd(a));
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((cyc < busy_until || mq.size() > 0 || mon_busy) && n < lim) begin
      cycle();
      n++;
    end
    chk("idle_timeout", n < lim, 1'b1);
    chk("exp_drained", exp_b.size(), 0);
    cycle(); cycle();
  endtask

  // Serial monitor: decode each frame from the line and compare with the model.
  initial begin
    int d, st, i;
    logic [9:0] bv;
    bit stable, ab;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        d = int'(div_m); st = cyc; stable = 1'b1; ab = 1'b0; bv = '0;
        mon_busy = 1'b1;
        for (i = 0; i < 10 * d && !ab; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) ab = 1'b1;
          else if (i % d == 0) bv[i / d] = tx;
          else if (tx !== bv[i / d]) stable = 1'b0;
        end
        mon_busy = 1'b0;
        if (!ab) begin
          nframes++;
          if (exp_b.size() == 0) chk("unexpected_frame", 1'b1, 1'b0);
          else begin
            chk("start_edge", st, exp_e.pop_front());
            chk("frame_byte", bv[8:1], exp_b.pop_front());
            chk("start_bit", bv[0], 1'b0);
            chk("stop_bit", bv[9], 1'b1);
            chk("bit_stable", stable, 1'b1);
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v, ra;
    int f0, d, n, gap;
    model_rst();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    chk("rst_tx", tx, 1'b1);
    chk("rst_irq", irq, 1'b1);
    bus_rd(16'hFF01, v); chk("rst_status", v, 16'h0002);
    bus_rd(16'hFF02, v); chk("rst_div", v, 16'd434);

    // single frame at DIV=4
    bus_wr(16'hFF02, 16'd4);
    bus_wr(16'hFF00, 16'h1A55);
    chk("tx_pre_start", tx, 1'b1);
    cycle();
    chk("tx_start", tx, 1'b0);
    repeat (4) cycle();
    chk("tx_bit0", tx, 1'b1);
    wait_idle(200);
    bus_rd(16'hFF01, v); chk("idle_status", v, 16'h0002);
    chk("idle_irq", irq, 1'b1);

    // three back-to-back frames at DIV=2
    bus_wr(16'hFF02, 16'd2);
    f0 = nframes;
    for (int i = 0; i < 3; i++) bus_wr(16'hFF00, 16'(8'hC0 + i));
    bus_rd(16'hFF01, v); chk("count_two", v[8:4], 5'd2);
    rd_chk("status_b2b", 16'hFF01);
    wait_idle(200);
    chk("frames_b2b", nframes - f0, 3);

    // overflow at DIV=100
    bus_wr(16'hFF02, 16'd100);
    f0 = nframes;
    for (int i = 0; i < 10; i++) bus_wr(16'hFF00, 16'(8'h30 + i));
    bus_rd(16'hFF01, v); chk("status_ovf", v, 16'h008D);
    bus_wr(16'hFF01, 16'h0008);
    bus_rd(16'hFF01, v); chk("status_ovf_clr", v, 16'h0085);
    wait_idle(12000);
    chk("frames_ovf", nframes - f0, 9);

    // address / read isolation
    bus_wr(16'hFF02, 16'd3);
    bus_wr(16'hFEFF, 16'h0011);
    bus_wr(16'hFF04, 16'h0022);
    bus_rd(16'hFF01, v); chk("iso_status", v, 16'h0002);
    bus_rd(16'hFF03, v); chk("iso_rsvd", v, 16'h0000);
    bus_rd(16'hFF00, v); chk("iso_txdata", v, 16'h0000);
    bus_rd(16'hFEFD, v); chk("iso_alias", v, 16'h0000);
    addr = 16'hFF01; #1 chk("iso_no_rd", rdata, 16'h0000);
    bus_wr(16'hFF02, 16'h0000);
    bus_rd(16'hFF02, v); chk("div_zero", v, 16'd1);
    repeat (40) cycle();
    chk("iso_frames", exp_b.size(), 0);

    // reset in the middle of data bit 3 of 8'hA5 (bit3 = 0)
    bus_wr(16'hFF02, 16'd8);
    bus_wr(16'hFF00, 16'h00A5);
    bus_wr(16'hFF00, 16'h003C);
    repeat (34) cycle();
    chk("pre_rst_tx", tx, 1'b0);
    rst_n = 1'b0;
    #1 chk("rst_tx_async", tx, 1'b1);
    chk("rst_irq_async", irq, 1'b1);
    bus_rd(16'hFF01, v); chk("rst_mid_status", v, 16'h0002);
    bus_rd(16'hFF02, v); chk("rst_mid_div", v, 16'd434);
    model_rst();
    repeat (3) cycle();
    rst_n = 1'b1;
    f0 = nframes;
    repeat (150) cycle();
    chk("post_rst_frames", nframes - f0, 0);
    chk("post_rst_tx", tx, 1'b1);

    // randomized traffic
    for (int r = 0; r < 8; r++) begin
      d = $urandom_range(1, 6);
      bus_wr(16'hFF02, 16'(d));
      n = $urandom_range(1, 14);
      for (int i = 0; i < n; i++) begin
        bus_wr(BASE, 16'($urandom));
        gap = $urandom_range(0, d * 8);
        repeat (gap) cycle();
        case ($urandom_range(0, 3))
          0: rd_chk("rand_status", 16'hFF01);
          1: begin
            ra = 16'hFEFE + 16'($urandom_range(0, 7));
            rd_chk("rand_addr", ra);
          end
          2: bus_wr(16'hFF01, 16'h0008);
          default: ;
        endcase
      end
      rd_chk("rand_status_mid", 16'hFF01);
      wait_idle(20000);
      rd_chk("rand_status_end", 16'hFF01);
      chk("rand_tx_idle", tx, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
